// File: rtl/vga_write_buffer.sv
// vga_write_buffer
//   Posted-write FIFO between the accelerator's VGA Avalon master (s_*) and
//   the pixel-buffer fabric port (m_*). Writes are queued one per cycle and
//   retired at the fabric's pace. A read first drains every queued write and
//   then passes through to the fabric.
// Ports:
//   clk, reset (async, active high)
//   s_address/s_read/s_write/s_writedata -> s_waitrequest/s_readdata : upstream
//   m_address/m_read/m_write/m_writedata <- m_waitrequest/m_readdata : fabric
//   idle  : FIFO empty and no read in progress (frame committed)
//   level : entry count, 0..DEPTH
module vga_write_buffer #(
  parameter int DEPTH  = 16,
  parameter int ADDR_W = 32,
  parameter int DATA_W = 16
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [ADDR_W-1:0]       s_address,
  input  logic                    s_read,
  input  logic                    s_write,
  input  logic [DATA_W-1:0]       s_writedata,
  output logic                    s_waitrequest,
  output logic [DATA_W-1:0]       s_readdata,
  output logic [ADDR_W-1:0]       m_address,
  output logic                    m_read,
  output logic                    m_write,
  output logic [DATA_W-1:0]       m_writedata,
  input  logic                    m_waitrequest,
  input  logic [DATA_W-1:0]       m_readdata,
  output logic                    idle,
  output logic [$clog2(DEPTH):0]  level
);
  localparam int PW = $clog2(DEPTH);

  typedef enum logic [1:0] {IDLE, DRAIN, READ} state_t;

  state_t            state, state_nxt;
  logic [ADDR_W-1:0] addr_mem [DEPTH];
  logic [DATA_W-1:0] data_mem [DEPTH];
  logic [PW:0]       wr_ptr, rd_ptr, wr_nxt, rd_nxt;
  logic              empty, full, push, pop;
  logic [PW-1:0]     head;

  assign head  = rd_ptr[PW-1:0];
  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[PW-1:0] == rd_ptr[PW-1:0]) && (wr_ptr[PW] != rd_ptr[PW]);
  assign level = wr_ptr - rd_ptr;
  assign idle  = empty && (state == IDLE);

  // Upstream stall. A write colliding with a read is a protocol error: the
  // read wins and the write is never pushed. The full check ignores writes
  // that coincide with a read so a full FIFO can never block the read path
  // (READ issues no pops, so that would deadlock).
  always_comb begin
    s_waitrequest = 1'b0;
    if (reset)
      s_waitrequest = 1'b1;
    else if (s_write && !s_read && full)
      s_waitrequest = 1'b1;
    else if (state == READ)
      s_waitrequest = m_waitrequest;
    else if (s_read)
      s_waitrequest = 1'b1;
  end

  assign push   = s_write && !s_read && !s_waitrequest;
  assign pop    = m_write && !m_waitrequest;
  assign wr_nxt = wr_ptr + (PW+1)'(push);
  assign rd_nxt = rd_ptr + (PW+1)'(pop);

  // Fabric side: head entry while writes may retire, pass-through in READ,
  // zeros otherwise.
  always_comb begin
    m_read      = (state == READ);
    m_write     = !empty && (state != READ);
    m_address   = '0;
    m_writedata = '0;
    s_readdata  = '0;
    if (m_read) begin
      m_address  = s_address;
      s_readdata = m_readdata;
    end else if (m_write) begin
      m_address   = addr_mem[head];
      m_writedata = data_mem[head];
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:  if (s_read) state_nxt = empty ? READ : DRAIN;
      // Leave once the FIFO will be empty after this edge.
      DRAIN: if (rd_nxt == wr_nxt) state_nxt = READ;
      READ:  if (!m_waitrequest) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state  <= IDLE;
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      state  <= state_nxt;
      wr_ptr <= wr_nxt;
      rd_ptr <= rd_nxt;
    end
  end

  // Storage needs no reset: entries are only visible between the pointers.
  always_ff @(posedge clk) begin
    if (push) begin
      addr_mem[wr_ptr[PW-1:0]] <= s_address;
      data_mem[wr_ptr[PW-1:0]] <= s_writedata;
    end
  end

endmodule

// File: tb/tb_vga_write_buffer.sv
module tb_vga_write_buffer;
  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] s_address;
  logic        s_read, s_write;
  logic [15:0] s_writedata;
  logic        s_waitrequest;
  logic [15:0] s_readdata;
  logic [31:0] m_address;
  logic        m_read, m_write;
  logic [15:0] m_writedata;
  logic        m_waitrequest;
  logic [15:0] m_readdata;
  logic        idle;
  logic [4:0]  level;

  int tests = 0;
  int fails = 0;
  int overlap_err = 0;
  logic [31:0] beats[$];

  vga_write_buffer #(.DEPTH(16), .ADDR_W(32), .DATA_W(16)) dut (
    .clk(clk), .reset(reset),
    .s_address(s_address), .s_read(s_read), .s_write(s_write),
    .s_writedata(s_writedata), .s_waitrequest(s_waitrequest),
    .s_readdata(s_readdata),
    .m_address(m_address), .m_read(m_read), .m_write(m_write),
    .m_writedata(m_writedata), .m_waitrequest(m_waitrequest),
    .m_readdata(m_readdata),
    .idle(idle), .level(level)
  );

  always #5 clk = ~clk;

  // Fabric observer: record every retired write beat.
  always @(negedge clk) begin
    if (m_write && !m_waitrequest) beats.push_back({m_address[15:0], m_writedata});
    if (m_write && m_read) overlap_err++;
  end

  typedef struct {
    logic        sw, sr;
    logic [31:0] addr;
    logic [15:0] wd;
    logic        mw;
    logic [15:0] mrd;
    logic        e_sw, e_mwr, e_mrd;
    logic [31:0] e_ma;
    logic [15:0] e_mwd, e_srd;
    logic [4:0]  e_lvl;
    logic        e_idle;
  } vec_t;

  function automatic vec_t mk(input logic sw, input logic sr, input logic [31:0] addr,
                              input logic [15:0] wd, input logic mw, input logic [15:0] mrd,
                              input logic esw, input logic emwr, input logic emrd,
                              input logic [31:0] ema, input logic [15:0] emwd,
                              input logic [15:0] esrd, input logic [4:0] elvl,
                              input logic eidle);
    vec_t v;
    v.sw = sw; v.sr = sr; v.addr = addr; v.wd = wd; v.mw = mw; v.mrd = mrd;
    v.e_sw = esw; v.e_mwr = emwr; v.e_mrd = emrd; v.e_ma = ema;
    v.e_mwd = emwd; v.e_srd = esrd; v.e_lvl = elvl; v.e_idle = eidle;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_idle(input string nm);
    int n = 0;
    while (!idle && n < 500) begin
      tick();
      n++;
    end
    chk(nm, idle, 1'b1);
  endtask

  task automatic drive(input logic sw, input logic sr, input logic [31:0] a,
                       input logic [15:0] d, input logic mw);
    s_write = sw; s_read = sr; s_address = a; s_writedata = d; m_waitrequest = mw;
  endtask

  initial begin
    vec_t vecs[$];
    int   sent, exp_lvl, lvl_err, both_cnt, cyc;
    logic push_ok, pop_ok;
    logic [31:0] e;

    reset = 1'b1;
    drive(0, 0, 0, 0, 0);
    m_readdata = 16'h0;
    #2;
    chk("rst_outputs", {s_waitrequest, m_write, m_read, m_address, m_writedata, s_readdata},
        {1'b1, 1'b0, 1'b0, 32'h0, 16'h0, 16'h0});
    chk("rst_level_idle", {level, idle}, {5'd0, 1'b1});
    @(posedge clk); #1;
    reset = 1'b0;

    // In-order retire: one push per cycle, fabric never stalls.
    vecs.push_back(mk(1,0,32'h0,16'hA000,0,16'h0, 0,0,0,32'h0,16'h0,16'h0,5'd0,1));
    vecs.push_back(mk(1,0,32'h2,16'hA001,0,16'h0, 0,1,0,32'h0,16'hA000,16'h0,5'd1,0));
    vecs.push_back(mk(1,0,32'h4,16'hA002,0,16'h0, 0,1,0,32'h2,16'hA001,16'h0,5'd1,0));
    vecs.push_back(mk(1,0,32'h6,16'hA003,0,16'h0, 0,1,0,32'h4,16'hA002,16'h0,5'd1,0));
    vecs.push_back(mk(0,0,32'h0,16'h0,   0,16'h0, 0,1,0,32'h6,16'hA003,16'h0,5'd1,0));
    vecs.push_back(mk(0,0,32'h0,16'h0,   0,16'h0, 0,0,0,32'h0,16'h0,16'h0,5'd0,1));
    // Read ordering: 3 writes queued, read drains them before m_read.
    vecs.push_back(mk(1,0,32'h10,16'hB0,1,16'hBEEF, 0,0,0,32'h0,16'h0,16'h0,5'd0,1));
    vecs.push_back(mk(1,0,32'h12,16'hB1,1,16'hBEEF, 0,1,0,32'h10,16'hB0,16'h0,5'd1,0));
    vecs.push_back(mk(1,0,32'h14,16'hB2,1,16'hBEEF, 0,1,0,32'h10,16'hB0,16'h0,5'd2,0));
    vecs.push_back(mk(0,1,32'h100,16'h0,1,16'hBEEF, 1,1,0,32'h10,16'hB0,16'h0,5'd3,0));
    vecs.push_back(mk(0,1,32'h100,16'h0,0,16'hBEEF, 1,1,0,32'h10,16'hB0,16'h0,5'd3,0));
    vecs.push_back(mk(0,1,32'h100,16'h0,0,16'hBEEF, 1,1,0,32'h12,16'hB1,16'h0,5'd2,0));
    vecs.push_back(mk(0,1,32'h100,16'h0,0,16'hBEEF, 1,1,0,32'h14,16'hB2,16'h0,5'd1,0));
    vecs.push_back(mk(0,1,32'h100,16'h0,0,16'hBEEF, 0,0,1,32'h100,16'h0,16'hBEEF,5'd0,0));
    vecs.push_back(mk(0,0,32'h0,16'h0,   0,16'hBEEF, 0,0,0,32'h0,16'h0,16'h0,5'd0,1));

    foreach (vecs[i]) begin
      drive(vecs[i].sw, vecs[i].sr, vecs[i].addr, vecs[i].wd, vecs[i].mw);
      m_readdata = vecs[i].mrd;
      #1;
      chk($sformatf("vec%0d", i),
          {s_waitrequest, m_write, m_read, m_address, m_writedata, s_readdata, level, idle},
          {vecs[i].e_sw, vecs[i].e_mwr, vecs[i].e_mrd, vecs[i].e_ma, vecs[i].e_mwd,
           vecs[i].e_srd, vecs[i].e_lvl, vecs[i].e_idle});
      tick();
    end

    // Protocol error: write and read together, read wins.
    drive(1, 1, 32'h200, 16'hE0, 0);
    m_readdata = 16'h1234;
    #1;
    chk("proto_stall", {s_waitrequest, m_read}, {1'b1, 1'b0});
    tick();
    chk("proto_read", {m_read, s_readdata, s_waitrequest}, {1'b1, 16'h1234, 1'b0});
    tick();
    chk("proto_no_push", level, 5'd0);
    drive(1, 0, 32'h202, 16'hE1, 0);
    #1;
    chk("proto_wr_acc", s_waitrequest, 1'b0);
    tick();
    drive(0, 0, 0, 0, 0);
    #1;
    chk("proto_wr_beat", {m_write, m_address, m_writedata}, {1'b1, 32'h202, 16'hE1});
    wait_idle("proto_idle");

    // Full boundary: 16 accepted under stall, 17th refused even as a pop occurs.
    beats.delete();
    for (int i = 0; i < 16; i++) begin
      drive(1, 0, 32'(2*i), 16'(16'hC000 + i), 1);
      #1;
      chk($sformatf("full_acc%0d", i), s_waitrequest, 1'b0);
      tick();
    end
    drive(1, 0, 32'h20, 16'hC010, 1);
    #1;
    chk("full_level", level, 5'd16);
    chk("full_refuse", s_waitrequest, 1'b1);
    tick();
    m_waitrequest = 1'b0;
    #1;
    chk("full_pop_refuse", {s_waitrequest, m_write}, {1'b1, 1'b1});
    tick();
    chk("full_after_pop", {s_waitrequest, level}, {1'b0, 5'd15});
    tick();
    s_write = 1'b0;
    wait_idle("full_idle");
    chk("full_beat_cnt", beats.size(), 17);
    for (int i = 0; i < 17 && i < beats.size(); i++) begin
      e = {16'(2*i), 16'(16'hC000 + i)};
      chk($sformatf("full_beat%0d", i), beats[i], e);
    end

    // Random push/pop across pointer wrap.
    beats.delete();
    sent = 0; exp_lvl = 0; lvl_err = 0; both_cnt = 0; cyc = 0;
    while (sent < 40 && cyc < 3000) begin
      drive(($urandom % 4) != 0, 0, 32'(16'h500 + 2*sent), 16'(16'hD000 + sent),
            ($urandom % 3) == 0);
      #1;
      if (int'(level) != exp_lvl) lvl_err++;
      push_ok = s_write && !s_waitrequest;
      pop_ok  = m_write && !m_waitrequest;
      if (push_ok && pop_ok) both_cnt++;
      exp_lvl = exp_lvl + int'(push_ok) - int'(pop_ok);
      if (push_ok) sent++;
      tick();
      cyc++;
    end
    drive(0, 0, 0, 0, 0);
    chk("rand_sent", sent, 40);
    wait_idle("rand_idle");
    chk("rand_level_err", lvl_err, 0);
    chk("rand_both_seen", both_cnt > 0, 1'b1);
    chk("rand_beat_cnt", beats.size(), 40);
    for (int i = 0; i < 40 && i < beats.size(); i++) begin
      e = {16'(16'h500 + 2*i), 16'(16'hD000 + i)};
      chk($sformatf("rand_beat%0d", i), beats[i], e);
    end

    // Reset mid-drain.
    for (int i = 0; i < 8; i++) begin
      drive(1, 0, 32'(16'h300 + 2*i), 16'(16'hF000 + i), 1);
      tick();
    end
    drive(0, 0, 0, 0, 1);
    #1;
    chk("rstd_pre", {level, m_write}, {5'd8, 1'b1});
    #1;
    reset = 1'b1;
    #1;
    chk("rstd_async", {m_write, s_waitrequest, m_address, m_writedata},
        {1'b0, 1'b1, 32'h0, 16'h0});
    chk("rstd_level_idle", {level, idle}, {5'd0, 1'b1});
    beats.delete();
    @(posedge clk); #1;
    reset = 1'b0;
    drive(1, 0, 32'h400, 16'h5555, 0);
    tick();
    drive(0, 0, 0, 0, 0);
    wait_idle("rstd_idle");
    chk("rstd_beat_cnt", beats.size(), 1);
    if (beats.size() > 0) chk("rstd_first_beat", beats[0], {16'h0400, 16'h5555});

    chk("no_rd_wr_overlap", overlap_err, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1);
  end
endmodule

// File: doc/vga_write_buffer.md
# vga_write_buffer

Posted-write FIFO between the accelerator's VGA Avalon master and the pixel-buffer fabric port. Every patch and update handler pixel write is queued at one per cycle and retired to the fabric at its own pace, so handlers stop stalling on fabric `waitrequest`. Reads are ordered behind all queued writes and then passed through to the fabric. The `idle` flag tells the top-level FSM when the frame is fully committed.

## Interface
- `DEPTH`, 16: number of FIFO entries; must be a power of 2, at least 2.
- `ADDR_W`, 32: address width.
- `DATA_W`, 16: data width.

- `clk`, in, 1: system clock.
- `reset`, in, 1: **asynchronous, active-high** reset.
- `s_address`, in, ADDR_W: upstream (accelerator) request address.
- `s_read`, in, 1: upstream read request.
- `s_write`, in, 1: upstream write request.
- `s_writedata`, in, DATA_W: upstream write data.
- `s_waitrequest`, out, 1: stall to upstream (combinational).
- `s_readdata`, out, DATA_W: read data; valid in the cycle `s_read` is high and `s_waitrequest` is low.
- `m_address`, out, ADDR_W: fabric address.
- `m_read`, out, 1: fabric read.
- `m_write`, out, 1: fabric write.
- `m_writedata`, out, DATA_W: fabric write data.
- `m_waitrequest`, in, 1: fabric stall.
- `m_readdata`, in, DATA_W: fabric read data.
- `idle`, out, 1: FIFO empty and FSM in IDLE.
- `level`, out, $clog2(DEPTH)+1: current entry count, 0..DEPTH.

## Operation
- **Storage:** DEPTH entries of {address, data}.
  - Write and read pointers are $clog2(DEPTH)+1 bits wide; the MSB is the wrap bit.
  - Full when the indices are equal and the wrap bits differ; empty when the pointers are equal.
- **Push:** occurs when `s_write & !s_waitrequest`.
- **Pop:** occurs when `m_write & !m_waitrequest`.
- **Fabric write side:** `m_write` = !empty while state is IDLE or DRAIN. `m_address` and `m_writedata` present the head entry.
- **Full FIFO:** a push is refused even if a pop happens in the same cycle. There is no bypass.
- **Push and pop together (non-full):** `level` is unchanged and order is preserved.
- **FSM states:**
  - IDLE:
    - `s_read` with FIFO not empty goes to DRAIN.
    - `s_read` with FIFO empty goes to READ.
  - DRAIN:
    - Writes are retired normally.
    - When the last entry pops (empty next cycle), go to READ.
  - READ:
    - `m_read` = 1, `m_write` = 0, `m_address` = `s_address`.
    - `s_readdata` = `m_readdata`.
    - `s_waitrequest` = `m_waitrequest`.
    - When `m_waitrequest` is low, go to IDLE.
- **`s_waitrequest`:**
  - 1 while `reset` is high.
  - Otherwise 1 when `s_write & full`.
  - Otherwise 1 when `s_read` is high in IDLE or DRAIN.
  - In READ it follows `m_waitrequest`.
- **`s_write` and `s_read` together:** this is an upstream protocol error. The read takes priority; the write is stalled (`s_waitrequest` = 1) and not pushed.
- **Idle output levels:** `m_address`, `m_writedata` and `s_readdata` are driven 0 when neither `m_write` nor `m_read` is asserted.
- **Reset, including mid-transfer:**
  - Pointers clear to 0 and the state goes to IDLE immediately.
  - Queued entries are discarded.
  - An in-flight fabric write is dropped. Reset is system-wide, so this is accepted.

## Timing
- **Reset values:**
  - `m_read`, `m_write`, `m_address`, `m_writedata`, `s_readdata` = 0.
  - `level` = 0, `idle` = 1, `s_waitrequest` = 1.
- **Write latency:** push at edge N gives `m_write` high in cycle N+1.
  - Sustained throughput is 1 word per cycle with `m_waitrequest` low.
- **Read from an empty FIFO:**
  - `s_read` is seen in cycle 0 with `s_waitrequest` = 1.
  - `m_read` is asserted in cycle 1.
  - Completes in cycle 1 at the earliest, giving a minimum of 1 wait cycle.
- **Read with k queued entries:**
  - `m_read` is asserted no earlier than one cycle after the k-th pop.
  - `m_read` and `m_write` are never high in the same cycle.
- **`level`** updates on the edge following a push or pop.
- **`idle`** rises on the cycle after the final pop. The top level waits for `idle` before returning to WAITING.

## Test plan
- **In-order retire:** 4 writes (addr 0x00..0x06 step 2, data 0xA000..0xA003), `m_waitrequest` = 0.
  - 4 consecutive `m_write` beats, matching and in order, each starting one cycle after its push.
  - `level` peaks at 1; `idle` = 1 after the last beat.
- **Full boundary:** `m_waitrequest` = 1 and 17 writes issued (DEPTH = 16).
  - 16 accepted, `level` = 16.
  - `s_waitrequest` = 1 on the 17th, even in the cycle `m_waitrequest` drops.
  - After release: 16 beats in order, then the 17th is accepted and retired.
- **Read ordering:** 3 writes queued under `m_waitrequest` = 1, then `s_read` at 0x100; release the stall with fabric `m_readdata` = 0xBEEF.
  - 3 write beats occur first.
  - Then `m_read` at 0x100.
  - `s_readdata` = 0xBEEF with `s_waitrequest` = 0; `idle` = 1 afterwards.
- **Simultaneous push/pop and wrap:** 40 writes with pseudo-random `s_write` and `m_waitrequest`.
  - `level` is constant on push+pop cycles.
  - All 40 words appear exactly once, in order, across pointer wrap.
- **Protocol-error priority:** `s_write` and `s_read` high in the same cycle.
  - No push occurs; the read completes.
  - The write is accepted only after `s_read` drops.
- **Reset mid-drain:** at `level` = 8 with `m_write` high, pulse `reset` asynchronously.
  - `m_write` = 0 and `s_waitrequest` = 1 without waiting for a clock edge.
  - `level` = 0 and `idle` = 1.
  - After release, the next write is the first beat seen on the fabric.
